// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encodings,
// grant codes and the IDLE-cycle arbitration function.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2
  } grant_e;

  // Data wins unless the fetch side has been passed over MAX_D_STREAK times in a row.
  // Nothing is granted in a cycle that carries a done pulse, so the completing stage
  // can present its next request before the bus is handed to anyone.
  function automatic grant_e pick_grant(
    input logic idle,
    input logic turnaround,
    input logic d_req,
    input logic f_ok,
    input logic starve
  );
    grant_e g;
    g = GRANT_NONE;
    if (idle && !turnaround) begin
      if (d_req && !(starve && f_ok)) begin
        g = GRANT_D;
      end else if (f_ok) begin
        g = GRANT_I;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait counter for one bus transaction: cleared while idle, counts BUSY cycles and
// flags the cycle in which the access has waited LIMIT-1 cycles.
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_en & (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEMORY stage,
// one transaction at a time, with data priority, a starvation guard, timeout and flush squash.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_flush,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_done,
  input  logic          i_mem_req,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_mem_done,
  output logic          o_bus_err,
  output logic          o_stall_if,
  output logic          o_stall_mem,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_ready,
  output logic [1:0]    o_dbg_state
);

  // Handshakes: a requester holds req (and its address/data) level-high until it sees
  // its one-cycle done pulse; the bus holds bus_req for the whole access and the memory
  // answers with a single-cycle bus_ready, after which bus_req drops for at least one cycle.

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e    r_state;
  logic [SW-1:0] r_streak;
  logic          r_squash;
  logic          r_if_done;
  logic          r_mem_done;
  logic          r_bus_err;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;

  logic   w_busy;
  logic   w_expire;
  logic   w_complete;
  logic   w_timeout;
  logic   w_squash_now;
  logic   w_f_ok;
  logic   w_starve;
  grant_e w_grant;

  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_complete   = w_busy & (i_bus_ready | w_expire);
    w_timeout    = w_expire & ~i_bus_ready;
    w_squash_now = r_squash | i_if_flush;
    w_f_ok       = i_if_req & ~i_if_flush;
    w_starve     = i_if_req & (r_streak == STREAK_MAX);
    w_grant      = pick_grant(r_state == ST_IDLE, r_if_done | r_mem_done,
                              i_mem_req, w_f_ok, w_starve);
  end

  arb_wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (~w_busy),
    .i_en    (w_busy),
    .o_expire(w_expire)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_streak    <= '0;
      r_squash    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_bus_err  <= 1'b0;

      // The streak only measures how long a waiting fetch has been passed over.
      if (!i_if_req || (w_grant == GRANT_I)) begin
        r_streak <= '0;
      end else if ((w_grant == GRANT_D) && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_squash <= 1'b0;
          if (w_grant == GRANT_D) begin
            r_state     <= ST_DBUSY;
            r_bus_we    <= i_mem_we;
            r_bus_addr  <= i_mem_addr;
            r_bus_wdata <= i_mem_wdata;
          end else if (w_grant == GRANT_I) begin
            r_state     <= ST_IBUSY;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= i_if_addr;
            r_bus_wdata <= '0;
          end
        end

        ST_IBUSY: begin
          if (i_if_flush) begin
            r_squash <= 1'b1;
          end
          if (w_complete) begin
            r_state  <= ST_IDLE;
            r_squash <= 1'b0;
            // A squashed fetch still finishes on the bus but is never reported.
            if (!w_squash_now) begin
              r_if_done  <= 1'b1;
              r_bus_err  <= w_timeout;
              r_if_rdata <= w_timeout ? '0 : i_bus_rdata;
            end
          end
        end

        ST_DBUSY: begin
          if (w_complete) begin
            r_state    <= ST_IDLE;
            r_bus_we   <= 1'b0;
            r_mem_done <= 1'b1;
            r_bus_err  <= w_timeout;
            if (w_timeout) begin
              r_mem_rdata <= '0;
            end else if (!r_bus_we) begin
              r_mem_rdata <= i_bus_rdata;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_if_done   = r_if_done;
  assign o_mem_rdata = r_mem_rdata;
  assign o_mem_done  = r_mem_done;
  assign o_bus_err   = r_bus_err;
  assign o_bus_req   = w_busy;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_dbg_state = r_state;

  // Stalls are held low during reset so every output reads 0 while it is asserted.
  assign o_stall_if  = i_if_req  & ~r_if_done  & ~i_reset;
  assign o_stall_mem = i_mem_req & ~r_mem_done & ~i_reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks plus a grant-order scoreboard
// fed by a bus monitor, with a latency-programmable memory responder.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          bus_err;
  logic          stall_if;
  logic          stall_mem;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] exp_q[$];

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_STREAK(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(if_rdata), .o_if_done(if_done),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_done(mem_done),
    .o_bus_err(bus_err), .o_stall_if(stall_if), .o_stall_mem(stall_mem),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // ---------------- memory responder ----------------
  int          busy_cnt = 0;
  int          cur_lat = 0;
  int          resp_lat = 1;
  bit          resp_rand = 1'b0;
  bit          resp_fixed = 1'b0;
  logic [31:0] resp_data = '0;
  bit          stray_ready = 1'b0;

  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    if (bus_req) begin
      busy_cnt++;
      if (busy_cnt == 1) cur_lat = resp_rand ? int'($urandom_range(1, 4)) : resp_lat;
    end else begin
      busy_cnt = 0;
    end
    bus_ready = stray_ready || (bus_req && (cur_lat != 0) && (busy_cnt == cur_lat));
    bus_rdata = resp_fixed ? resp_data : mem_model(bus_addr);
  end

  // ---------------- scoreboard: grant order ----------------
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL grant_order: got grant addr %h want no grant", bus_addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (bus_addr !== e) begin
          n_err++;
          $display("FAIL grant_order: got addr %h want %h", bus_addr, e);
        end
      end
    end
    prev_req = bus_req;
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q_empty(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_pending: got %0d grants outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if_req = 1'b1;
    mem_req = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus_req, if_done, mem_done, bus_err, stall_if, stall_mem, bus_we} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {bus_req, if_done, mem_done, bus_err, stall_if, stall_mem, bus_we});
    end
    n_vec++;
    if ({bus_addr, bus_wdata} !== 64'b0) begin
      n_err++;
      $display("FAIL reset_bus: got addr %h wdata %h want 0", bus_addr, bus_wdata);
    end
    n_vec++;
    if ({if_rdata, mem_rdata} !== 64'b0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h %h want 0", if_rdata, mem_rdata);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
    mem_req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_lone_fetch();
    resp_fixed = 1'b1;
    resp_data = 32'h0050_0093;
    resp_lat = 3;
    if_req = 1'b1;
    if_addr = 32'h40;
    exp_q.push_back(32'h40);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus_req !== (c >= 1 && c <= 3)) begin
        n_err++;
        $display("FAIL lone_bus_req c=%0d: got %b want %b", c, bus_req, (c >= 1 && c <= 3));
      end
      n_vec++;
      if (if_done !== (c == 4)) begin
        n_err++;
        $display("FAIL lone_if_done c=%0d: got %b want %b", c, if_done, (c == 4));
      end
      n_vec++;
      if (stall_if !== (c <= 3)) begin
        n_err++;
        $display("FAIL lone_stall_if c=%0d: got %b want %b", c, stall_if, (c <= 3));
      end
      if (c == 1) begin
        n_vec++;
        if (bus_we !== 1'b0) begin
          n_err++;
          $display("FAIL lone_bus_we: got %b want 0", bus_we);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (if_rdata !== 32'h0050_0093) begin
          n_err++;
          $display("FAIL lone_if_rdata: got %h want 00500093", if_rdata);
        end
      end
      step();
    end
    if_req = 1'b0;
    resp_fixed = 1'b0;
    step();
    check_q_empty("lone");
  endtask

  task automatic test_data_over_fetch();
    bit got;
    resp_lat = 1;
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h100;
    mem_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1;
    if_addr = 32'h44;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h44);
    step();
    @(negedge clk);
    n_vec++;
    if ({bus_req, bus_we, bus_wdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL dvf_store_bus: got req %b we %b wdata %h want 1 1 deadbeef",
               bus_req, bus_we, bus_wdata);
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL dvf_mem_done: got no done want done within 20 cycles");
    end
    n_vec++;
    if ({mem_rdata, bus_err, stall_mem} !== {32'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL dvf_store_result: got rdata %h err %b stall %b want 0 0 0",
               mem_rdata, bus_err, stall_mem);
    end
    step();
    mem_req = 1'b0;
    mem_we = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_done) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got || if_rdata !== mem_model(32'h44)) begin
      n_err++;
      $display("FAIL dvf_fetch: got done %b rdata %h want 1 %h", got, if_rdata, mem_model(32'h44));
    end
    step();
    if_req = 1'b0;
    step();
    check_q_empty("dvf");
  endtask

  task automatic test_back_to_back();
    int nd;
    int ni;
    bit d_seen;
    bit i_seen;
    resp_rand = 1'b1;
    mem_we = 1'b0;
    mem_req = 1'b1;
    mem_addr = 32'h200;
    if_req = 1'b1;
    if_addr = 32'h1000;
    for (int j = 0; j < 4; j++) exp_q.push_back(32'h200 + 32'(4 * j));
    exp_q.push_back(32'h1000);
    for (int j = 4; j < 8; j++) exp_q.push_back(32'h200 + 32'(4 * j));
    exp_q.push_back(32'h1004);
    for (int j = 8; j < 10; j++) exp_q.push_back(32'h200 + 32'(4 * j));
    exp_q.push_back(32'h1008);
    nd = 0;
    ni = 0;
    for (int cyc = 0; cyc < 600 && (nd < 10 || ni < 3); cyc++) begin
      @(negedge clk);
      d_seen = mem_done;
      i_seen = if_done;
      if (d_seen) begin
        n_vec++;
        if (mem_rdata !== mem_model(mem_addr)) begin
          n_err++;
          $display("FAIL b2b_load %0d: got %h want %h", nd, mem_rdata, mem_model(mem_addr));
        end
        nd++;
      end
      if (i_seen) begin
        n_vec++;
        if (if_rdata !== mem_model(if_addr)) begin
          n_err++;
          $display("FAIL b2b_fetch %0d: got %h want %h", ni, if_rdata, mem_model(if_addr));
        end
        ni++;
      end
      step();
      if (d_seen) begin
        if (nd == 10) mem_req = 1'b0;
        else mem_addr = 32'h200 + 32'(4 * nd);
      end
      if (i_seen) begin
        if (ni == 3) if_req = 1'b0;
        else if_addr = 32'h1000 + 32'(4 * ni);
      end
    end
    n_vec++;
    if (nd != 10 || ni != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d loads %0d fetches want 10 3", nd, ni);
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    resp_rand = 1'b0;
    step();
    check_q_empty("b2b");
  endtask

  task automatic test_flush();
    bit got;
    // flush mid-IBUSY, new PC presented on the following cycle
    resp_lat = 3;
    if_req = 1'b1;
    if_addr = 32'h80;
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h300);
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin
        if_flush = 1'b0;
        if_addr = 32'h300;
      end
      @(negedge clk);
      n_vec++;
      if (if_done !== 1'b0) begin
        n_err++;
        $display("FAIL flush_squash c=%0d: got if_done %b want 0", c, if_done);
      end
      step();
    end
    @(negedge clk);
    n_vec++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
      n_err++;
      $display("FAIL flush_regrant: got req %b addr %h want 1 00000300", bus_req, bus_addr);
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_done) begin
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got || if_rdata !== mem_model(32'h300)) begin
      n_err++;
      $display("FAIL flush_newpc: got done %b rdata %h want 1 %h", got, if_rdata, mem_model(32'h300));
    end
    step();
    if_req = 1'b0;
    step();

    // flush in IDLE blocks only that cycle's fetch grant
    resp_lat = 1;
    if_req = 1'b1;
    if_addr = 32'h500;
    if_flush = 1'b1;
    exp_q.push_back(32'h500);
    step();
    if_flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_block: got bus_req %b want 0", bus_req);
    end
    step();
    @(negedge clk);
    n_vec++;
    if (bus_req !== 1'b1) begin
      n_err++;
      $display("FAIL flush_idle_next: got bus_req %b want 1", bus_req);
    end
    step();
    @(negedge clk);
    n_vec++;
    if (if_done !== 1'b1 || if_rdata !== mem_model(32'h500)) begin
      n_err++;
      $display("FAIL flush_idle_done: got %b %h want 1 %h", if_done, if_rdata, mem_model(32'h500));
    end
    step();
    if_req = 1'b0;
    step();

    // flush in the same cycle as bus_ready still squashes
    resp_lat = 2;
    if_req = 1'b1;
    if_addr = 32'h600;
    exp_q.push_back(32'h600);
    step();
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_done, bus_req} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_at_ready: got done %b req %b want 0 0", if_done, bus_req);
    end
    step();
    check_q_empty("flush");
  endtask

  task automatic test_timeout();
    resp_lat = 0;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h700;
    exp_q.push_back(32'h700);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_req, mem_done, bus_err} !== {(c >= 1 && c <= 8), (c == 9), (c == 9)}) begin
        n_err++;
        $display("FAIL timeout_seq c=%0d: got req/done/err %b%b%b want %b%b%b", c,
                 bus_req, mem_done, bus_err, (c >= 1 && c <= 8), (c == 9), (c == 9));
      end
      if (c == 1) begin
        n_vec++;
        if (dbg_state !== ST_DBUSY) begin
          n_err++;
          $display("FAIL timeout_state: got %0d want %0d", dbg_state, ST_DBUSY);
        end
      end
      if (c == 9) begin
        n_vec++;
        if (mem_rdata !== 32'h0) begin
          n_err++;
          $display("FAIL timeout_rdata: got %h want 0", mem_rdata);
        end
      end
      step();
    end
    mem_req = 1'b0;
    step();
    stray_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus_req, mem_done, bus_err} !== 3'b000) begin
      n_err++;
      $display("FAIL stray_ready_a: got %b%b%b want 000", bus_req, mem_done, bus_err);
    end
    step();
    stray_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_done, if_done, bus_req} !== 3'b000 || mem_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL stray_ready_b: got done %b%b req %b rdata %h want 000 0",
               mem_done, if_done, bus_req, mem_rdata);
    end
    step();
    check_q_empty("timeout");
  endtask

  task automatic test_reset_mid();
    resp_lat = 0;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h800;
    exp_q.push_back(32'h800);
    repeat (3) step();
    reset = 1'b1;
    #2;
    n_vec++;
    if ({bus_req, stall_mem, mem_done, bus_err} !== 4'b0000 || dbg_state !== ST_IDLE
        || bus_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: got req %b stall %b done %b err %b state %0d addr %h want all 0",
               bus_req, stall_mem, mem_done, bus_err, dbg_state, bus_addr);
    end
    mem_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus_req, mem_done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: got req %b done %b want 0 0", bus_req, mem_done);
    end
    step();
    resp_lat = 2;
    mem_req = 1'b1;
    mem_addr = 32'h900;
    exp_q.push_back(32'h900);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({bus_req, mem_done} !== {(c >= 1 && c <= 2), (c == 3)}) begin
        n_err++;
        $display("FAIL post_reset c=%0d: got req/done %b%b want %b%b", c, bus_req, mem_done,
                 (c >= 1 && c <= 2), (c == 3));
      end
      if (c == 3) begin
        n_vec++;
        if (mem_rdata !== mem_model(32'h900)) begin
          n_err++;
          $display("FAIL post_reset_rdata: got %h want %h", mem_rdata, mem_model(32'h900));
        end
      end
      step();
    end
    mem_req = 1'b0;
    step();
    check_q_empty("reset_mid");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    if_flush = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_data_over_fetch();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid();
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
